// File: rtl/aes_axil_master.sv
// aes_axil_master: AXI4-Lite initiator that loads plaintext and key into the
// memory-mapped AES peripheral, waits a settle interval, then reads back the
// ciphertext. Every transaction is single-beat, with at most one outstanding.
// Optional watchdog: define AES_AXIL_TIMEOUT_EN to abort a stalled handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; snapshot key/pt on start
// S_WR     | AW and W offered for word r_idx (0-3 pt, 4-7 key)
// S_WB     | waiting for the write response of word r_idx
// S_SETTLE | SETTLE_CYCLES idle cycles before the first read address
// S_RA     | AR offered for ciphertext word r_idx
// S_RD     | waiting for read data of word r_idx
// S_DONE   | ct_out and resp_err valid, done pulse

module aes_axil_master #(
  parameter int ADDR_WIDTH    = 6,
  parameter int DATA_WIDTH    = 32,  // only 32 is supported
  parameter int BASE_ADDR     = 0,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    start,
  input  logic [127:0]            key_in,
  input  logic [127:0]            pt_in,
  output logic                    busy,
  output logic                    done,
  output logic [127:0]            ct_out,
  output logic                    resp_err,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WB, S_SETTLE, S_RA, S_RD, S_DONE
  } state_t;

  localparam logic [15:0] SETTLE_LOAD = 16'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_t         r_state, w_state_nxt;
  logic [1:0]     r_rst_sync;
  logic           w_rst_n;
  logic [127:0]   r_key, r_pt, r_ct_cap, r_ct_out, w_ct_merge;
  logic [2:0]     r_idx;
  logic [15:0]    r_settle_cnt;
  logic           r_err;
  logic           r_awvalid, r_wvalid, r_arvalid;
  logic           r_aw_done, r_w_done, r_b_done, r_r_done;
  logic           w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic           w_aw_ok, w_w_ok, w_b_ok, w_r_ok;
  logic           w_enter, w_timeout, w_tmo_fire;
  logic [31:0]    w_wdata;

  // reset synchronizer: assertion is immediate, release follows two ACLK edges
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_aw_hs = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs  = r_wvalid & M_AXI_WREADY;
  assign w_b_hs  = M_AXI_BVALID & M_AXI_BREADY;
  assign w_ar_hs = r_arvalid & M_AXI_ARREADY;
  assign w_r_hs  = M_AXI_RVALID & M_AXI_RREADY;
  assign w_aw_ok = r_aw_done | w_aw_hs;
  assign w_w_ok  = r_w_done | w_w_hs;
  assign w_b_ok  = r_b_done | w_b_hs;
  assign w_r_ok  = r_r_done | w_r_hs;

`ifdef AES_AXIL_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        w_wdog_state;
  assign w_wdog_state = (r_state == S_WR) || (r_state == S_WB) ||
                        (r_state == S_RA) || (r_state == S_RD);
  assign w_timeout    = w_wdog_state && (r_wdog == 16'hFFFF);

  // watchdog: restarts on every state change, counts while a handshake is awaited
  always_ff @(posedge ACLK or negedge w_rst_n) begin
    if (!w_rst_n)                                 r_wdog <= '0;
    else if (w_enter)                             r_wdog <= '0;
    else if (w_wdog_state && r_wdog != 16'hFFFF)  r_wdog <= r_wdog + 16'd1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge ACLK or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state; a handshake completing on the watchdog's last cycle wins
  always_comb begin
    w_state_nxt = r_state;
    w_tmo_fire  = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_WR;
      S_WR:     if (w_aw_ok && w_w_ok) w_state_nxt = S_WB;
      S_WB:     if (w_b_ok) begin
                  if (r_idx == 3'd7) w_state_nxt = (SETTLE_CYCLES == 0) ? S_RA : S_SETTLE;
                  else               w_state_nxt = S_WR;
                end
      S_SETTLE: if (r_settle_cnt == 16'd0) w_state_nxt = S_RA;
      S_RA:     if (w_ar_hs) w_state_nxt = S_RD;
      S_RD:     if (w_r_ok) w_state_nxt = (r_idx == 3'd3) ? S_DONE : S_RA;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_timeout && (w_state_nxt == r_state)) begin
      w_tmo_fire  = 1'b1;
      w_state_nxt = S_DONE;
    end
  end

  assign w_enter = (w_state_nxt != r_state);

  // FSM outputs; READYs follow state only, so a timeout drops them in S_DONE
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    M_AXI_BREADY = 1'b0;
    M_AXI_RREADY = 1'b0;
    case (r_state)
      S_WR, S_WB: begin
        busy         = 1'b1;
        M_AXI_BREADY = ~r_b_done;
      end
      S_SETTLE:   busy = 1'b1;
      S_RA, S_RD: begin
        busy         = 1'b1;
        M_AXI_RREADY = ~r_r_done;
      end
      S_DONE:     done = 1'b1;
      default:    busy = 1'b0;
    endcase
  end

  // write data word: plaintext words first, then key words, MSW first
  always_comb begin
    w_wdata = '0;
    case (r_idx)
      3'd0: w_wdata = r_pt[127:96];
      3'd1: w_wdata = r_pt[95:64];
      3'd2: w_wdata = r_pt[63:32];
      3'd3: w_wdata = r_pt[31:0];
      3'd4: w_wdata = r_key[127:96];
      3'd5: w_wdata = r_key[95:64];
      3'd6: w_wdata = r_key[63:32];
      3'd7: w_wdata = r_key[31:0];
      default: w_wdata = '0;
    endcase
  end

  // capture register with the word arriving this cycle merged in
  always_comb begin
    w_ct_merge = r_ct_cap;
    if (w_r_hs) begin
      case (r_idx[1:0])
        2'd0: w_ct_merge[127:96] = M_AXI_RDATA;
        2'd1: w_ct_merge[95:64]  = M_AXI_RDATA;
        2'd2: w_ct_merge[63:32]  = M_AXI_RDATA;
        2'd3: w_ct_merge[31:0]   = M_AXI_RDATA;
        default: w_ct_merge = r_ct_cap;
      endcase
    end
  end

  // datapath: snapshot, channel valids, sticky error, word index, result
  always_ff @(posedge ACLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_key        <= '0;
      r_pt         <= '0;
      r_ct_cap     <= '0;
      r_ct_out     <= '0;
      r_idx        <= '0;
      r_settle_cnt <= '0;
      r_err        <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_b_done     <= 1'b0;
      r_r_done     <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_key <= key_in;
        r_pt  <= pt_in;
        r_idx <= '0;
        r_err <= 1'b0;
      end
      if (w_aw_hs) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_wvalid <= 1'b0;
        r_w_done <= 1'b1;
      end
      if (w_b_hs) begin
        r_b_done <= 1'b1;
        if (M_AXI_BRESP != 2'b00) r_err <= 1'b1;
      end
      if (w_ar_hs) r_arvalid <= 1'b0;
      if (w_r_hs) begin
        r_r_done <= 1'b1;
        r_ct_cap <= w_ct_merge;
        if (M_AXI_RRESP != 2'b00) r_err <= 1'b1;
      end
      if (r_state == S_WB && w_b_ok)
        r_idx <= (r_idx == 3'd7) ? 3'd0 : r_idx + 3'd1;
      if (r_state == S_RD && w_r_ok) begin
        if (r_idx == 3'd3) r_ct_out <= w_ct_merge;
        else               r_idx    <= r_idx + 3'd1;
      end
      if (r_state == S_SETTLE && r_settle_cnt != 16'd0)
        r_settle_cnt <= r_settle_cnt - 16'd1;
      if (w_enter) begin
        case (w_state_nxt)
          S_WR: begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_b_done  <= 1'b0;
          end
          S_SETTLE: r_settle_cnt <= SETTLE_LOAD;
          S_RA: begin
            r_arvalid <= 1'b1;
            r_r_done  <= 1'b0;
          end
          default: ;
        endcase
      end
      if (w_tmo_fire) begin
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b0;
        r_arvalid <= 1'b0;
        r_err     <= 1'b1;
      end
    end
  end

  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_AWADDR  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({r_idx, 2'b00});
  assign M_AXI_ARADDR  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(32) + ADDR_WIDTH'({r_idx[1:0], 2'b00});
  assign M_AXI_WDATA   = w_wdata;
  assign M_AXI_WSTRB   = '1;
  assign ct_out        = r_ct_out;
  assign resp_err      = r_err;

endmodule

// File: tb/tb_aes_axil_master.sv
// Testbench for aes_axil_master: randomized AXI4-Lite slave standing in for the
// AES peripheral, with expected writes and results queued at each start.
module tb_aes_axil_master;

  logic         ACLK, ARESETN, start;
  logic [127:0] key_in, pt_in, ct_out;
  logic         busy, done, resp_err;
  logic [5:0]   M_AXI_AWADDR, M_AXI_ARADDR;
  logic         M_AXI_AWVALID, M_AXI_AWREADY;
  logic [31:0]  M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]   M_AXI_WSTRB;
  logic         M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]   M_AXI_BRESP, M_AXI_RRESP;
  logic         M_AXI_BVALID, M_AXI_BREADY;
  logic         M_AXI_ARVALID, M_AXI_ARREADY;
  logic         M_AXI_RVALID, M_AXI_RREADY;

  aes_axil_master dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .key_in(key_in), .pt_in(pt_in),
    .busy(busy), .done(done), .ct_out(ct_out), .resp_err(resp_err),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  typedef struct { logic [5:0] a; logic [31:0] d; } wr_t;
  wr_t          exp_wr[$];
  logic [128:0] exp_res[$];   // {resp_err, ct}

  int  checks = 0, failures = 0;
  int  n_done = 0, n_wr = 0;
  bit  inj_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Peripheral model: real FIPS-197 answers for the two known vectors,
  // a simple key/plaintext mix for everything else.
  function automatic logic [127:0] ref_ct(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] r;
    logic [31:0]  kw, pw;
    if (k == C1_KEY && p == C1_PT) return C1_CT;
    if (k == B_KEY && p == B_PT)   return B_CT;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      kw = k[127-32*i -: 32];
      pw = p[127-32*i -: 32];
      r[127-32*i -: 32] = pw ^ {kw[15:0], kw[31:16]} ^ (32'hA5C3_0000 + 32'(i));
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    ACLK = 0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

  // AXI slave: sample handshakes at negedge, react 1 ns after the following posedge
  logic [31:0] mem [0:7];
  bit          s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;
  logic [5:0]  s_awaddr, s_araddr, aw_a, ar_a;
  logic [31:0] s_wdata, w_d;
  logic [3:0]  s_wstrb;
  bit          got_aw, got_w, b_pend, r_pend;
  int          b_wait, r_wait;
  logic [1:0]  b_resp_q;
  logic [127:0] s_ct;
  wr_t         s_e;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
    M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
    got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0; b_wait = 0; r_wait = 0; b_resp_q = 0;
    forever begin
      @(negedge ACLK);
      s_aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;  s_awaddr = M_AXI_AWADDR;
      s_w_hs  = M_AXI_WVALID && M_AXI_WREADY;    s_wdata = M_AXI_WDATA; s_wstrb = M_AXI_WSTRB;
      s_b_hs  = M_AXI_BVALID && M_AXI_BREADY;
      s_ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;  s_araddr = M_AXI_ARADDR;
      s_r_hs  = M_AXI_RVALID && M_AXI_RREADY;
      @(posedge ACLK);
      #1;
      if (!ARESETN) begin
        got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
        M_AXI_BVALID = 0; M_AXI_RVALID = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
      end else begin
        if (s_b_hs) begin M_AXI_BVALID = 0; b_pend = 0; end
        if (s_r_hs) begin M_AXI_RVALID = 0; r_pend = 0; end
        if (s_aw_hs) begin
          chk("dup_aw", got_aw, 0);
          chk("aw_while_b_pending", b_pend, 0);
          got_aw = 1; aw_a = s_awaddr;
        end
        if (s_w_hs) begin
          chk("dup_w", got_w, 0);
          chk("wstrb", s_wstrb, 4'hF);
          got_w = 1; w_d = s_wdata;
        end
        if (got_aw && got_w) begin
          got_aw = 0; got_w = 0;
          if (exp_wr.size() == 0) begin
            checks++; failures++;
            $display("FAIL extra_write actual=addr_%0h expected=none", aw_a);
          end else begin
            s_e = exp_wr.pop_front();
            chk("write_addr", aw_a, s_e.a);
            chk("write_data", w_d, s_e.d);
          end
          if (aw_a[5] == 1'b0) mem[aw_a[4:2]] = w_d;
          n_wr++;
          b_pend = 1;
          b_wait = $urandom_range(0, 5);
          b_resp_q = (inj_err && aw_a == 6'h14) ? 2'b10 : 2'b00;
        end
        if (b_pend && !M_AXI_BVALID) begin
          if (b_wait == 0) begin M_AXI_BVALID = 1; M_AXI_BRESP = b_resp_q; end
          else b_wait--;
        end
        if (s_ar_hs) begin
          chk("ar_while_r_pending", r_pend, 0);
          chk("araddr_range", s_araddr[5:4], 2'b10);
          r_pend = 1; r_wait = $urandom_range(0, 5); ar_a = s_araddr;
        end
        if (r_pend && !M_AXI_RVALID) begin
          if (r_wait == 0) begin
            s_ct = ref_ct({mem[4], mem[5], mem[6], mem[7]}, {mem[0], mem[1], mem[2], mem[3]});
            M_AXI_RVALID = 1; M_AXI_RRESP = 2'b00;
            M_AXI_RDATA = s_ct[127-32*int'(ar_a[3:2]) -: 32];
          end else r_wait--;
        end
        M_AXI_AWREADY = 1'($urandom_range(0, 1));
        M_AXI_WREADY  = 1'($urandom_range(0, 1));
        M_AXI_ARREADY = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: result scoreboard on done, VALID/address stability every cycle
  logic [128:0] m_e;
  bit           p_rst = 0, p_aw = 0, p_w = 0, p_ar = 0;
  logic [5:0]   p_awaddr, p_araddr;
  logic [31:0]  p_wdata;
  initial begin
    forever begin
      @(negedge ACLK);
      if (done) begin
        n_done++;
        if (exp_res.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          m_e = exp_res.pop_front();
          chk("ct_out", ct_out, m_e[127:0]);
          chk("resp_err", resp_err, m_e[128]);
          chk("busy_at_done", busy, 0);
        end
      end
      if (ARESETN && p_rst) begin
        if (p_aw) begin chk("awvalid_hold", M_AXI_AWVALID, 1); chk("awaddr_stable", M_AXI_AWADDR, p_awaddr); end
        if (p_w)  begin chk("wvalid_hold", M_AXI_WVALID, 1);   chk("wdata_stable", M_AXI_WDATA, p_wdata); end
        if (p_ar) begin chk("arvalid_hold", M_AXI_ARVALID, 1); chk("araddr_stable", M_AXI_ARADDR, p_araddr); end
      end
      p_rst = ARESETN;
      p_aw = M_AXI_AWVALID && !M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
      p_w  = M_AXI_WVALID && !M_AXI_WREADY;   p_wdata  = M_AXI_WDATA;
      p_ar = M_AXI_ARVALID && !M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
    end
  end

  // issue a start and queue what the peripheral should see and return
  task automatic issue(input logic [127:0] k, input logic [127:0] p, input bit inj);
    logic [255:0] sk;
    wr_t e;
    @(negedge ACLK);
    key_in = k; pt_in = p; start = 1; inj_err = inj;
    sk = {p, k};
    for (int i = 0; i < 8; i++) begin
      e.a = 6'(4 * i);
      e.d = sk[255-32*i -: 32];
      exp_wr.push_back(e);
    end
    exp_res.push_back({inj, ref_ct(k, p)});
    @(negedge ACLK);
    start = 0;
    key_in = rnd128(); pt_in = rnd128();
  endtask

  task automatic run(input logic [127:0] k, input logic [127:0] p, input bit inj,
                     input bit mid, input bit ds);
    int cyc, d0;
    d0 = n_done;
    issue(k, p, inj);
    if (mid) begin
      repeat (6) @(negedge ACLK);
      key_in = rnd128(); start = 1;
      @(negedge ACLK);
      start = 0;
    end
    cyc = 0;
    while (!done && cyc < 3000) begin @(negedge ACLK); cyc++; end
    if (!done) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_done expected=done");
      return;
    end
    if (ds) start = 1;
    @(negedge ACLK);
    start = 0;
    repeat (20) @(negedge ACLK);
    chk("single_done", n_done, d0 + 1);
    chk("idle_after_done", busy, 0);
  endtask

  task automatic reset_mid(input logic [127:0] k, input logic [127:0] p);
    int cyc, w0;
    w0 = n_wr;
    issue(k, p, 0);
    cyc = 0;
    while (!(n_wr == w0 + 2 && M_AXI_AWVALID) && cyc < 2000) begin @(negedge ACLK); cyc++; end
    chk("third_write_reached", n_wr, w0 + 2);
    ARESETN = 0;
    #1;
    chk("rst_awvalid", M_AXI_AWVALID, 0);
    chk("rst_wvalid", M_AXI_WVALID, 0);
    chk("rst_arvalid", M_AXI_ARVALID, 0);
    chk("rst_bready", M_AXI_BREADY, 0);
    chk("rst_rready", M_AXI_RREADY, 0);
    exp_wr.delete();
    exp_res.delete();
    repeat (3) @(negedge ACLK);
    ARESETN = 1;
    repeat (4) @(negedge ACLK);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ct_out", ct_out, 0);
    chk("post_rst_resp_err", resp_err, 0);
    chk("post_rst_done", done, 0);
  endtask

  initial begin
    ARESETN = 0; start = 0; key_in = '0; pt_in = '0;
    repeat (3) @(negedge ACLK);
    chk("reset_awvalid", M_AXI_AWVALID, 0);
    chk("reset_wvalid", M_AXI_WVALID, 0);
    chk("reset_arvalid", M_AXI_ARVALID, 0);
    chk("reset_bready", M_AXI_BREADY, 0);
    chk("reset_rready", M_AXI_RREADY, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ct_out", ct_out, 0);
    chk("reset_resp_err", resp_err, 0);
    ARESETN = 1;
    repeat (4) @(negedge ACLK);

    run(C1_KEY, C1_PT, 0, 0, 0);
    chk("c1_ct_hold", ct_out, C1_CT);
    run(B_KEY, B_PT, 0, 1, 1);
    chk("b_ct_hold", ct_out, B_CT);
    run(rnd128(), rnd128(), 1, 0, 0);
    run(rnd128(), rnd128(), 0, 1, 0);
    reset_mid(rnd128(), rnd128());
    run(C1_KEY, C1_PT, 0, 0, 1);
    for (int i = 0; i < 6; i++)
      run(rnd128(), rnd128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    chk("no_leftover_results", exp_res.size(), 0);
    chk("no_leftover_writes", exp_wr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_axil_master.md
Name: aes_axil_master

Overview:
- AXI4-Lite initiator that drives the memory-mapped AES encrypt peripheral from hardware, with no CPU in the loop.
- Takes a 128-bit key and plaintext on a start pulse, then issues 8 single-beat writes: plaintext 0x00–0x0C, then key 0x10–0x1C.
- Waits a settle interval, then issues 4 single-beat reads of ciphertext from 0x20–0x2C and presents the 128-bit result with a done pulse.

Parameters:
ADDR_WIDTH, 6, AXI address width
DATA_WIDTH, 32, AXI data width (only 32 supported)
BASE_ADDR, 0, peripheral base address added to every register offset
SETTLE_CYCLES, 2, idle cycles between the last write response and the first read address

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request; sampled only in IDLE
key_in  in  128  key; bits [127:96] go to offset 0x10
pt_in  in  128  plaintext; bits [127:96] go to offset 0x00
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when ct_out is valid
ct_out  out  128  ciphertext; offset 0x20 maps to bits [127:96]
resp_err  out  1  valid with done; 1 if any BRESP/RRESP != OKAY
M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY  AXI4-Lite master channels at ADDR_WIDTH/DATA_WIDTH; directions mirror the slave

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - All VALIDs, BREADY, RREADY, busy, done and resp_err = 0.
  - ct_out = 0; FSM = IDLE; internal key/pt snapshot = 0.
  - Reset mid-transaction drops all VALIDs immediately. No transaction resumes after release.
- IDLE: on start=1, snapshot key_in/pt_in, clear word counter idx=0 and resp_err, go to WR. start while busy is ignored.
- WR:
  - Assert AWVALID and WVALID in the same cycle.
  - AWADDR = BASE_ADDR + 4*idx; WDATA = snapshot word idx (idx 0–3 plaintext, 4–7 key, MSW first); WSTRB = 4'hF.
  - Each VALID drops the cycle after its READY is seen high. AW and W may complete in different cycles; neither is reissued.
  - When both are accepted, go to WB.
- WB:
  - BREADY = 1 until BVALID is seen. A BVALID arriving during WR is also accepted.
  - On a non-OKAY BRESP, set resp_err (sticky).
  - If idx==7, go to SETTLE; else idx++ and go to WR.
- SETTLE: count SETTLE_CYCLES cycles, then idx=0 and go to RA. With SETTLE_CYCLES=0, go straight to RA.
- RA:
  - ARVALID = 1 with ARADDR = BASE_ADDR + 0x20 + 4*idx, held until ARREADY.
  - RREADY = 1 from RA entry. An RVALID arriving before ARREADY is accepted.
- RD:
  - On RVALID&&RREADY, capture RDATA into ct word idx; a non-OKAY RRESP sets resp_err.
  - Deassert ARVALID if still high.
  - If idx==3, go to DONE; else idx++ and go to RA.
  - Only one outstanding transaction at any time.
- DONE: update ct_out from the capture register, pulse done for 1 cycle, busy=0, return to IDLE. A start in the DONE cycle is ignored.
- Handshake rules:
  - VALID never depends combinationally on READY.
  - ADDR/DATA are stable while VALID is high.
  - The block tolerates READY asserted before VALID.
- Minimum latency start→done: 8×(≥2) + SETTLE_CYCLES + 4×(≥2) cycles. ct_out holds its value until the next done.

Optional Feature:
Macro AES_AXIL_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog restarts on every state entry in WR/WB/RA/RD.
  - If it reaches 16'hFFFF before the awaited handshake, drop all VALID/READY and set resp_err=1.
  - Pulse done with ct_out unchanged, then return to IDLE.
- Undefined: no watchdog; the block waits indefinitely. No extra ports either way.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> writes 0x00=00112233 … 0x1C=0c0d0e0f in order; ct_out=69c4e0d86a7b0430d8cdb78070b4c55a; resp_err=0.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct_out=3925841d02dc09fbdc118597196a0b32; exactly one done pulse.
- Slave model with randomized READY/BVALID/RVALID delays (0–5 cycles) and AWREADY/WREADY in different cycles -> same ciphertext; no duplicate writes; VALIDs stable until accepted.
- Slave returns BRESP=2'b10 on write idx 5 -> sequence completes, resp_err=1 with done; the next clean run gives resp_err=0.
- ARESETN asserted during the third write -> all VALIDs 0 in the same cycle; after release busy=0, ct_out=0; a new start completes correctly.
- start pulsed while busy and during the DONE cycle -> ignored; key_in changed mid-run does not alter the written key words.
